// File: rtl/pcie_egress_reader_if.sv
// Egress FIFO, downstream sink and counter-read signals for pcie_egress_reader.
interface pcie_egress_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 5
);
  logic [3:0]            empty;
  logic [3:0]            almost_full;
  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_in3;
  logic                  sink_ready;
  logic                  req;
  logic [2:0]            idx;
  logic [3:0]            pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [CNT_WIDTH-1:0]  counter_out;
  logic                  counter_valid;
  logic                  idle_out;

  modport master (
    output empty, almost_full, data_in0, data_in1, data_in2, data_in3,
    output sink_ready, req, idx,
    input  pop, data_out, valid_out, counter_out, counter_valid, idle_out
  );

  modport slave (
    input  empty, almost_full, data_in0, data_in1, data_in2, data_in3,
    input  sink_ready, req, idx,
    output pop, data_out, valid_out, counter_out, counter_valid, idle_out
  );
endinterface

// File: rtl/pcie_egress_reader.sv
// Drains four egress FIFOs into one downstream stream: almost-full priority,
// otherwise round-robin, two-cycle pop-to-data pipeline, per-channel word counters.
module pcie_egress_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  pcie_egress_reader_if.slave  bus
);
  typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

  state_t                state;
  logic [1:0]            last;
  logic [1:0]            pop_idx;
  logic [1:0]            c;
  logic                  pop_any;
  logic [3:0]            avail;
  logic                  s1_valid;
  logic [1:0]            s1_ch;
  logic [1:0]            out_ch;
  logic [DATA_WIDTH-1:0] word;
  logic [CNT_WIDTH-1:0]  count [4];

  assign avail = ~bus.empty;

  // Loops scan from the least preferred candidate so the preferred one is written last.
  always_comb begin
    pop_idx = '0;
    pop_any = 1'b0;
    c       = '0;
    if (state == ACTIVE && bus.sink_ready && !init && avail != 4'b0000) begin
      pop_any = 1'b1;
      if ((avail & bus.almost_full) != 4'b0000) begin
        for (int unsigned i = 0; i < 4; i++) begin
          c = 2'(3 - i);
          if (avail[c] && bus.almost_full[c]) pop_idx = c;
        end
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          c = last + 2'(4 - i);
          if (avail[c]) pop_idx = c;
        end
      end
    end
  end

  assign bus.pop = pop_any ? (4'b0001 << pop_idx) : 4'b0000;

  always_comb begin
    word = bus.data_in0;
    case (s1_ch)
      2'd1:    word = bus.data_in1;
      2'd2:    word = bus.data_in2;
      2'd3:    word = bus.data_in3;
      default: word = bus.data_in0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= INIT;
      last              <= 2'd3;
      s1_valid          <= 1'b0;
      s1_ch             <= '0;
      out_ch            <= '0;
      bus.data_out      <= '0;
      bus.valid_out     <= 1'b0;
      bus.counter_out   <= '0;
      bus.counter_valid <= 1'b0;
      bus.idle_out      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) count[i] <= '0;
    end else begin
      // A read issued alongside a delivery sees the value before that delivery counts.
      bus.counter_valid <= bus.req;
      bus.counter_out   <= (bus.req && !bus.idx[2]) ? count[bus.idx[1:0]] : '0;
      if (init) begin
        state         <= INIT;
        bus.idle_out  <= 1'b0;
        s1_valid      <= 1'b0;
        bus.valid_out <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) count[i] <= '0;
      end else begin
        s1_valid      <= pop_any;
        s1_ch         <= pop_idx;
        bus.valid_out <= s1_valid;
        out_ch        <= s1_ch;
        if (pop_any) last <= pop_idx;
        if (s1_valid) bus.data_out <= word;
        if (bus.valid_out) count[out_ch] <= count[out_ch] + 1'b1;
        case (state)
          INIT: begin
            state        <= IDLE;
            bus.idle_out <= 1'b1;
          end
          IDLE: begin
            if (bus.empty != 4'b1111) begin
              state        <= ACTIVE;
              bus.idle_out <= 1'b0;
            end else begin
              bus.idle_out <= 1'b1;
            end
          end
          ACTIVE: begin
            if (bus.empty == 4'b1111 && !s1_valid) begin
              state        <= IDLE;
              bus.idle_out <= 1'b1;
            end else begin
              bus.idle_out <= 1'b0;
            end
          end
          default: begin
            state        <= INIT;
            bus.idle_out <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pcie_egress_reader.sv
// Scoreboard bench for pcie_egress_reader: FIFO model feeds the DUT, expected words are queued at pop time.
module tb_pcie_egress_reader;
  localparam int DW = 12;
  localparam int CW = 5;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    word_t       data;
    logic [1:0]  ch;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic init;
  always #5 clk = ~clk;

  pcie_egress_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  pcie_egress_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus)
  );

  word_t         fq [4][$];
  exp_t          exp_q[$];
  logic [3:0]    pop_seq[$];
  logic [CW-1:0] cnt_model [4];
  int            checks = 0;
  int            failures = 0;
  int unsigned   cyc = 0;
  int unsigned   delivered = 0;
  int unsigned   flush_cnt = 0;
  int unsigned   flush_seen = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void update_empty();
    bus.empty = {fq[3].size() == 0, fq[2].size() == 0, fq[1].size() == 0, fq[0].size() == 0};
  endfunction

  // FIFO model on the rising edge, scoreboard/monitor on the falling edge.
  initial begin : model
    logic [3:0]    popped;
    int unsigned   pop_cyc;
    bit            req_pend;
    logic [CW-1:0] req_exp;
    exp_t          e;
    word_t         w;
    popped   = '0;
    pop_cyc  = 0;
    req_pend = 1'b0;
    req_exp  = '0;
    for (int k = 0; k < 4; k++) cnt_model[k] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 4; k++) begin
        if (popped[2'(k)] && fq[k].size() > 0) begin
          w = fq[k].pop_front();
          case (k)
            0:       bus.data_in0 = w;
            1:       bus.data_in1 = w;
            2:       bus.data_in2 = w;
            default: bus.data_in3 = w;
          endcase
          exp_q.push_back('{data: w, ch: 2'(k), due: pop_cyc + 32'd2});
        end
      end
      update_empty();
      @(negedge clk);
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        exp_q.delete();
        req_pend = 1'b0;
        for (int k = 0; k < 4; k++) cnt_model[k] = '0;
      end
      popped  = bus.pop;
      pop_cyc = cyc;
      if (mon_en) begin
        if (reset && bus.pop != 4'b0000) begin
          check("pop_onehot", 32'($onehot(bus.pop)), 1);
          check("pop_on_empty", 32'(bus.pop & bus.empty), 0);
          pop_seq.push_back(bus.pop);
        end
        if (req_pend) begin
          check("counter_valid", 32'(bus.counter_valid), 1);
          check("counter_out", 32'(bus.counter_out), 32'(req_exp));
        end else begin
          check("counter_valid_idle", 32'(bus.counter_valid), 0);
        end
        req_pend = reset && bus.req;
        req_exp  = bus.idx[2] ? '0 : cnt_model[bus.idx[1:0]];
        if (bus.valid_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(bus.data_out), 32'(e.data));
            check("latency", cyc, e.due);
            cnt_model[e.ch] = cnt_model[e.ch] + 1'b1;
            delivered++;
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          check("missing_word", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input word_t w);
    fq[k].push_back(w);
    update_empty();
  endtask

  task automatic flush();
    flush_cnt++;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int t = 0;
    while (pop_seq.size() < n && t < budget) begin
      tick();
      t++;
    end
    check("pop_wait", pop_seq.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!(bus.idle_out === 1'b1 && exp_q.size() == 0 && bus.empty == 4'b1111) && t < budget) begin
      tick();
      t++;
    end
    check("idle_reached", 32'(bus.idle_out), 1);
  endtask

  task automatic read_all(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req = 1'b1;
      bus.idx = 3'(i);
      tick();
    end
    bus.req = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    int unsigned d0;
    reset = 1'b0;
    init  = 1'b0;
    bus.sink_ready  = 1'b1;
    bus.req         = 1'b0;
    bus.idx         = '0;
    bus.almost_full = '0;
    bus.data_in0    = '0;
    bus.data_in1    = '0;
    bus.data_in2    = '0;
    bus.data_in3    = '0;
    update_empty();

    // reset values, then init for 3 cycles
    repeat (2) tick();
    check("rst_idle_out", 32'(bus.idle_out), 0);
    check("rst_valid_out", 32'(bus.valid_out), 0);
    check("rst_data_out", 32'(bus.data_out), 0);
    check("rst_counter_out", 32'(bus.counter_out), 0);
    check("rst_counter_valid", 32'(bus.counter_valid), 0);
    check("rst_pop", 32'(bus.pop), 0);
    reset  = 1'b1;
    init   = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    check("init_idle_out", 32'(bus.idle_out), 0);
    init = 1'b0;
    tick();
    check("idle_after_init", 32'(bus.idle_out), 1);
    check("idle_pop", 32'(bus.pop), 0);
    check("idle_valid_out", 32'(bus.valid_out), 0);

    // two channels, plain round-robin from channel 0
    d0 = delivered;
    pop_seq.delete();
    push(0, 12'h0FF);
    push(1, 12'h1F7);
    wait_pops(2, 20);
    check("rr_first", 32'(pop_seq[0]), 32'h1);
    check("rr_second", 32'(pop_seq[1]), 32'h2);
    wait_idle(30);
    check("rr_delivered", delivered - d0, 2);

    // almost_full priority, then round-robin resumes after channel 2
    bus.almost_full = 4'b0100;
    pop_seq.delete();
    for (int i = 0; i < 10; i++) push(2, word_t'(12'h200 + i));
    for (int i = 0; i < 6; i++) begin
      push(0, word_t'(12'h000 + i));
      push(1, word_t'(12'h100 + i));
      push(3, word_t'(12'h300 + i));
    end
    wait_pops(4, 20);
    bus.almost_full = 4'b0000;
    wait_pops(8, 20);
    for (int i = 0; i < 4; i++) check("af_priority", 32'(pop_seq[i]), 32'h4);
    check("af_resume_ch3", 32'(pop_seq[4]), 32'h8);
    check("af_resume_ch0", 32'(pop_seq[5]), 32'h1);
    check("af_resume_ch1", 32'(pop_seq[6]), 32'h2);
    check("af_resume_ch2", 32'(pop_seq[7]), 32'h4);
    wait_idle(100);

    // sink_ready drops one cycle after a pop
    d0 = delivered;
    pop_seq.delete();
    for (int i = 0; i < 4; i++) push(3, word_t'(12'hA30 + i));
    wait_pops(1, 20);
    bus.sink_ready = 1'b0;
    repeat (3) tick();
    check("stall_no_pop", pop_seq.size(), 1);
    check("stall_word_delivered", delivered - d0, 1);
    bus.sink_ready = 1'b1;
    tick();
    check("stall_resume", pop_seq.size(), 2);
    check("stall_resume_ch", 32'(pop_seq[1]), 32'h8);
    wait_idle(40);
    check("stall_all_delivered", delivered - d0, 4);

    // counter reads, including reads overlapping deliveries
    read_all(8);
    bus.req = 1'b1;
    bus.idx = 3'd1;
    for (int i = 0; i < 3; i++) push(1, word_t'(12'h5A0 + i));
    repeat (10) tick();
    bus.req = 1'b0;
    tick();
    wait_idle(30);

    // init clears counters; 32 words on channel 2 wrap its counter to 0
    init = 1'b1;
    tick();
    flush();
    tick();
    init = 1'b0;
    tick();
    read_all(4);
    for (int i = 0; i < 32; i++) push(2, word_t'(12'h700 + i));
    wait_idle(200);
    bus.req = 1'b1;
    bus.idx = 3'd2;
    tick();
    check("wrap_counter_out", 32'(bus.counter_out), 0);
    check("wrap_counter_valid", 32'(bus.counter_valid), 1);
    bus.idx = 3'd6;
    tick();
    check("idx6_counter_out", 32'(bus.counter_out), 0);
    check("idx6_counter_valid", 32'(bus.counter_valid), 1);
    bus.req = 1'b0;
    tick();

    // init while words are in flight
    d0 = delivered;
    pop_seq.delete();
    push(0, 12'hB01);
    push(0, 12'hB02);
    wait_pops(1, 20);
    init = 1'b1;
    tick();
    flush();
    repeat (2) tick();
    check("init_flush_no_valid", delivered - d0, 0);
    read_all(4);
    init = 1'b0;
    wait_idle(30);

    // reset while two words are in flight, then last-served restarts at 3
    d0 = delivered;
    pop_seq.delete();
    push(3, 12'hC01);
    push(3, 12'hC02);
    wait_pops(1, 20);
    reset = 1'b0;
    tick();
    flush();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("reset_flush_no_valid", delivered - d0, 0);
    check("reset_to_idle", 32'(bus.idle_out), 1);
    read_all(4);
    pop_seq.delete();
    push(1, 12'hD01);
    push(0, 12'hD00);
    wait_pops(1, 20);
    check("reset_last_served", 32'(pop_seq[0]), 32'h1);
    wait_idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
